// File: rtl/arc_ucode_pkg.sv
// Shared microword layout, condition codes, sequencer states and helpers for
// the ARC microsequencer.
package arc_ucode_pkg;

  localparam int MIR_W     = 41;
  localparam int A_MSB     = 40;
  localparam int A_LSB     = 35;
  localparam int AMUX_BIT  = 34;
  localparam int B_MSB     = 33;
  localparam int B_LSB     = 28;
  localparam int BMUX_BIT  = 27;
  localparam int C_MSB     = 26;
  localparam int C_LSB     = 21;
  localparam int CMUX_BIT  = 20;
  localparam int RD_BIT    = 19;
  localparam int WR_BIT    = 18;
  localparam int ALU_MSB   = 17;
  localparam int ALU_LSB   = 14;
  localparam int COND_MSB  = 13;
  localparam int COND_LSB  = 11;
  localparam int JADDR_MSB = 10;
  localparam int JADDR_LSB = 0;

  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  localparam logic [3:0] ALU_NOP = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } seq_state_e;

  // Dispatch target: op and op3 select a 4-word slot in the upper half of the store.
  function automatic logic [10:0] decode_addr(input logic [31:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

  // Neutralise a microword: no register write, no PSR update, optionally no memory access.
  function automatic logic [MIR_W-1:0] squash_word(input logic [MIR_W-1:0] w,
                                                   input logic keep_mem);
    logic [MIR_W-1:0] r;
    r                  = w;
    r[C_MSB:C_LSB]     = 6'd0;
    r[CMUX_BIT]        = 1'b0;
    r[ALU_MSB:ALU_LSB] = ALU_NOP;
    if (!keep_mem) begin
      r[RD_BIT] = 1'b0;
      r[WR_BIT] = 1'b0;
    end else begin
      r[RD_BIT] = w[RD_BIT];
      r[WR_BIT] = w[WR_BIT];
    end
    return r;
  endfunction

endpackage

// File: rtl/arc_next_addr.sv
// Combinational next-microaddress select from the COND field, flags and IR.
module arc_next_addr
  import arc_ucode_pkg::*;
#(
  parameter int CS_AW = 11
) (
  input  logic [CS_AW-1:0] csar,
  input  logic [2:0]       cond,
  input  logic [CS_AW-1:0] jaddr,
  input  logic [3:0]       psr,
  input  logic [31:0]      ir,
  output logic [CS_AW-1:0] next_addr
);

  logic [CS_AW-1:0] incr_s;

  assign incr_s = csar + CS_AW'(1);

  // psr is {n,z,v,c}
  always_comb begin
    next_addr = incr_s;
    case (cond)
      COND_NEXT:   next_addr = incr_s;
      COND_N:      next_addr = psr[3] ? jaddr : incr_s;
      COND_Z:      next_addr = psr[2] ? jaddr : incr_s;
      COND_V:      next_addr = psr[1] ? jaddr : incr_s;
      COND_C:      next_addr = psr[0] ? jaddr : incr_s;
      COND_IR13:   next_addr = ir[13] ? jaddr : incr_s;
      COND_JUMP:   next_addr = jaddr;
      COND_DECODE: next_addr = CS_AW'(decode_addr(ir));
      default:     next_addr = incr_s;
    endcase
  end

endmodule

// File: rtl/arc_microsequencer.sv
// ARC control unit: CSAR, microword issue, memory-stall handling with timeout
// fault, and run/halt gating.
module arc_microsequencer
  import arc_ucode_pkg::*;
#(
  parameter int               CS_AW       = 11,
  parameter logic [CS_AW-1:0] START_ADDR  = '0,
  parameter int               MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic [3:0]       psr,
  input  logic [MIR_W-1:0] cs_data,
  output logic [CS_AW-1:0] cs_addr,
  output logic [MIR_W-1:0] mir,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic             mem_ack,
  output logic             stall,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      instr_count
);

  seq_state_e       state_q;
  logic [CS_AW-1:0] csar_q;
  logic [7:0]       tmo_q;
  logic [31:0]      icount_q;

  logic             access_s;
  logic             stall_s;
  logic [MIR_W-1:0] mir_s;
  logic [CS_AW-1:0] next_s;
  logic [2:0]       cond_s;

  assign access_s = cs_data[RD_BIT] | cs_data[WR_BIT];
  assign cond_s   = cs_data[COND_MSB:COND_LSB];

  arc_next_addr #(.CS_AW(CS_AW)) u_next_addr (
    .csar      (csar_q),
    .cond      (cond_s),
    .jaddr     (cs_data[JADDR_MSB:JADDR_LSB]),
    .psr       (psr),
    .ir        (ir),
    .next_addr (next_s)
  );

  // Microword issue: full word when executing, squashed while stalled or not running.
  always_comb begin
    stall_s = 1'b0;
    mir_s   = squash_word(cs_data, 1'b0);
    case (state_q)
      ST_RUN: begin
        if (access_s && !mem_ack) begin
          stall_s = 1'b1;
          mir_s   = squash_word(cs_data, 1'b1);
        end else begin
          mir_s   = cs_data;
        end
      end
      default: begin
        stall_s = 1'b0;
        mir_s   = squash_word(cs_data, 1'b0);
      end
    endcase
  end

  // Sequencer FSM, CSAR, stall timeout counter and dispatch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      csar_q   <= START_ADDR;
      tmo_q    <= 8'd0;
      icount_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stall_s) begin
            if (tmo_q == 8'(MEM_TIMEOUT)) begin
              state_q <= ST_FAULT;
            end else begin
              tmo_q <= tmo_q + 8'd1;
            end
          end else begin
            tmo_q  <= 8'd0;
            csar_q <= next_s;
            if (cond_s == COND_DECODE) begin
              icount_q <= icount_q + 32'd1;
              if (!run) begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_FAULT;
      endcase
    end
  end

  assign cs_addr     = csar_q;
  assign mir         = mir_s;
  assign mem_rd      = mir_s[RD_BIT];
  assign mem_wr      = mir_s[WR_BIT];
  assign stall       = stall_s;
  assign halted      = (state_q != ST_RUN);
  assign fault       = (state_q == ST_FAULT);
  assign instr_count = icount_q;

endmodule

// File: tb/tb_arc_microsequencer.sv
// Directed self-checking bench for arc_microsequencer with a behavioural control store.
module tb_arc_microsequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] ir;
  logic [3:0]  psr;
  logic [40:0] cs_data;
  logic [10:0] cs_addr;
  logic [40:0] mir;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic        stall;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  logic [40:0] rom [0:2047];

  int checks;
  int failures;

  arc_microsequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .ir          (ir),
    .psr         (psr),
    .cs_data     (cs_data),
    .cs_addr     (cs_addr),
    .mir         (mir),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  assign cs_data = rom[cs_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Microword with nonzero C, CMUX and ALU so squashing is visible.
  function automatic logic [40:0] mk(input logic [2:0] cond, input logic [10:0] jaddr,
                                     input logic rd, input logic wr);
    return {6'h2A, 1'b1, 6'h15, 1'b0, 6'h0B, 1'b1, rd, wr, 4'b0011, cond, jaddr};
  endfunction

  function automatic logic [40:0] exp_nop(input logic [40:0] w);
    return {w[40:27], 6'h00, 1'b0, 1'b0, 1'b0, 4'b1000, w[13:0]};
  endfunction

  function automatic logic [40:0] exp_stall(input logic [40:0] w);
    return {w[40:27], 6'h00, 1'b0, w[19], w[18], 4'b1000, w[13:0]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b1; psr = 4'd0; ir = 32'd0;
    #1;
    checks++; if (cs_addr !== 11'h000) begin failures++; $display("FAIL reset_csar got=%h exp=%h", cs_addr, 11'h000); end
    checks++; if ({halted, fault, stall, mem_rd, mem_wr} !== 5'b10000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {halted, fault, stall, mem_rd, mem_wr}, 5'b10000); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_icount got=%0d exp=0", instr_count); end
    checks++; if (mir !== exp_nop(rom[0])) begin failures++; $display("FAIL reset_mir_nop got=%h exp=%h", mir, exp_nop(rom[0])); end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    checks++; if (halted !== 1'b1 || cs_addr !== 11'h000) begin failures++; $display("FAIL idle_hold halted=%b csar=%h exp halted=1 csar=000", halted, cs_addr); end
  endtask

  task automatic test_start_sequence();
    run = 1'b1;
    #1;
    checks++; if (cs_addr !== 11'h000 || halted !== 1'b1) begin failures++; $display("FAIL run_cycle csar=%h halted=%b exp 000/1", cs_addr, halted); end
    next_cycle();
    checks++; if (cs_addr !== 11'h000 || halted !== 1'b0) begin failures++; $display("FAIL first_exec csar=%h halted=%b exp 000/0", cs_addr, halted); end
    checks++; if (mir !== rom[0]) begin failures++; $display("FAIL first_mir got=%h exp=%h", mir, rom[0]); end
    next_cycle();
    checks++; if (cs_addr !== 11'h001 || mir !== rom[1]) begin failures++; $display("FAIL seq_1 csar=%h mir=%h exp 001/%h", cs_addr, mir, rom[1]); end
    next_cycle();
    checks++; if (cs_addr !== 11'h002) begin failures++; $display("FAIL seq_2 got=%h exp=002", cs_addr); end
  endtask

  task automatic test_branch();
    psr = 4'b0100;
    next_cycle();
    checks++; if (cs_addr !== 11'h005) begin failures++; $display("FAIL jump_to_5 got=%h exp=005", cs_addr); end
    next_cycle();
    checks++; if (cs_addr !== 11'h040) begin failures++; $display("FAIL z_taken got=%h exp=040", cs_addr); end
    psr = 4'b0000;
    next_cycle();
    next_cycle();
    checks++; if (cs_addr !== 11'h006) begin failures++; $display("FAIL z_not_taken got=%h exp=006", cs_addr); end
  endtask

  task automatic test_decode();
    next_cycle();
    ir = 32'h8008_0000;
    mem_ack = 1'b0;
    #1;
    checks++; if (cs_addr !== 11'h010 || instr_count !== 32'd0) begin failures++; $display("FAIL at_decode csar=%h icount=%0d exp 010/0", cs_addr, instr_count); end
    next_cycle();
    checks++; if (cs_addr !== 11'h604) begin failures++; $display("FAIL decode_target got=%h exp=604", cs_addr); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL icount_1 got=%0d exp=1", instr_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) run = 1'b0;
      #1;
      checks++; if (stall !== 1'b1 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || cs_addr !== 11'h604) begin
        failures++; $display("FAIL stall_cycle%0d stall=%b rd=%b wr=%b csar=%h exp 1/1/0/604", i, stall, mem_rd, mem_wr, cs_addr);
      end
      checks++; if (mir !== exp_stall(rom[11'h604])) begin failures++; $display("FAIL stall_mir%0d got=%h exp=%h", i, mir, exp_stall(rom[11'h604])); end
      next_cycle();
    end
    mem_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || mir !== rom[11'h604]) begin failures++; $display("FAIL ack_cycle stall=%b mir=%h exp 0/%h", stall, mir, rom[11'h604]); end
    next_cycle();
    checks++; if (cs_addr !== 11'h605 || halted !== 1'b0) begin failures++; $display("FAIL after_ack csar=%h halted=%b exp 605/0", cs_addr, halted); end
    run = 1'b1;
  endtask

  task automatic test_wrap_and_halt();
    next_cycle();
    checks++; if (cs_addr !== 11'h7FF) begin failures++; $display("FAIL at_top got=%h exp=7ff", cs_addr); end
    next_cycle();
    checks++; if (cs_addr !== 11'h000) begin failures++; $display("FAIL wrap got=%h exp=000", cs_addr); end
    rom[0] = mk(3'b111, 11'h123, 1'b0, 1'b0);
    ir  = 32'h4010_0000;
    run = 1'b0;
    next_cycle();
    checks++; if (halted !== 1'b1 || cs_addr !== 11'h508) begin failures++; $display("FAIL halt_decode halted=%b csar=%h exp 1/508", halted, cs_addr); end
    checks++; if (instr_count !== 32'd2) begin failures++; $display("FAIL icount_2 got=%0d exp=2", instr_count); end
    checks++; if (mir !== exp_nop(rom[11'h508])) begin failures++; $display("FAIL idle_mir got=%h exp=%h", mir, exp_nop(rom[11'h508])); end
    next_cycle();
    checks++; if (halted !== 1'b1 || cs_addr !== 11'h508) begin failures++; $display("FAIL stay_idle halted=%b csar=%h exp 1/508", halted, cs_addr); end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    rom[0] = mk(3'b000, 11'h000, 1'b1, 1'b0);
    mem_ack = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    run = 1'b1;
    next_cycle();
    for (int i = 0; i < 256; i++) begin
      if (stall !== 1'b1 || fault !== 1'b0 || mem_rd !== 1'b1) bad++;
      next_cycle();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL timeout_window bad_cycles=%0d exp=0", bad); end
    checks++; if (fault !== 1'b1 || mem_rd !== 1'b0 || halted !== 1'b1 || stall !== 1'b0) begin
      failures++; $display("FAIL fault_entry fault=%b rd=%b halted=%b stall=%b exp 1/0/1/0", fault, mem_rd, halted, stall);
    end
    checks++; if (mir !== exp_nop(rom[0]) || cs_addr !== 11'h000) begin failures++; $display("FAIL fault_mir mir=%h csar=%h exp %h/000", mir, cs_addr, exp_nop(rom[0])); end
    mem_ack = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (fault !== 1'b1 || cs_addr !== 11'h000) begin failures++; $display("FAIL fault_sticky fault=%b csar=%h exp 1/000", fault, cs_addr); end
    rst = 1'b1;
    #1;
    checks++; if (fault !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL fault_clear fault=%b halted=%b exp 0/1", fault, halted); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_async_abort();
    mem_ack = 1'b0;
    run = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (stall !== 1'b1 || mem_rd !== 1'b1) begin failures++; $display("FAIL abort_pre stall=%b rd=%b exp 1/1", stall, mem_rd); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b0 || stall !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL abort_async rd=%b stall=%b halted=%b exp 0/0/1", mem_rd, stall, halted); end
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int i = 0; i < 2048; i++) rom[i] = mk(3'b000, 11'(i), 1'b0, 1'b0);
    rom[2]        = mk(3'b110, 11'h005, 1'b0, 1'b0);
    rom[5]        = mk(3'b010, 11'h040, 1'b0, 1'b0);
    rom[11'h040]  = mk(3'b110, 11'h005, 1'b0, 1'b0);
    rom[6]        = mk(3'b110, 11'h010, 1'b0, 1'b0);
    rom[11'h010]  = mk(3'b111, 11'h3AB, 1'b0, 1'b0);
    rom[11'h604]  = mk(3'b000, 11'h0C3, 1'b1, 1'b0);
    rom[11'h605]  = mk(3'b110, 11'h7FF, 1'b0, 1'b0);
    rom[11'h7FF]  = mk(3'b000, 11'h055, 1'b0, 1'b0);
    test_reset();
    test_start_sequence();
    test_branch();
    test_decode();
    test_stall();
    test_wrap_and_halt();
    test_timeout();
    test_async_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
